i2c_slave_regctrl: RTL and testbench
====================================

Name: i2c_slave_regctrl

Overview:
- Controller sequencing the I2C slave core's byte events onto an internal 8-bit register bus.
- Converts slave write events into bus writes and slave read requests into bus reads, and presents the fetched byte back to the slave before its data phase.
- Keeps an auto-incrementing register pointer.
- Sits between the I2C slave core and the peripheral register bank.

Parameters:
- ADDR_W, 8, register bus address width; ADDR_W >= 8, slave register address zero-extended.
- TIMEOUT, 255, maximum cycles waited for gnt_i or rvalid_i before aborting; 1..65535.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  block enable; low aborts and holds IDLE.
- slv_addr_i  in  8  register address received by slave core.
- slv_read_i  in  1  slave read flag, level; rises when a read address is ACKed.
- slv_valid_i  in  1  slave write-data flag, level; rises when a write data byte is ACKed.
- slv_data_i  in  8  byte received by slave core.
- slv_data_o  out  8  byte to transmit, to slave core data input.
- req_o  out  1  bus request.
- we_o  out  1  bus write enable; 1 write, 0 read.
- addr_o  out  ADDR_W  bus address.
- wdata_o  out  8  bus write data.
- gnt_i  in  1  bus grant; request accepted this cycle.
- rvalid_i  in  1  read data valid.
- rdata_i  in  8  read data.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky timeout flag.
- ovf_o  out  1  sticky event-overrun flag.
- clr_i  in  1  clears err_o and ovf_o.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0 except slv_data_o = 8'hFF. Internal state: ptr = 0, pending flags = 0, state IDLE. Reset mid-transfer drops req_o the next cycle, with no completion.
- Edge detection: registered copies of slv_valid_i and slv_read_i.
  - wr_ev = rising edge of slv_valid_i.
  - rd_ev = rising edge of slv_read_i.
- Address tracking: when slv_addr_i differs from its registered copy, ptr <= slv_addr_i.
- State machine: IDLE, WR_REQ, RD_REQ, RD_WAIT.
  - IDLE, wr_ev (or wr pending): addr_o = slv_addr_i, wdata_o = slv_data_i, we_o = 1, req_o = 1 next cycle; go WR_REQ. ptr <= slv_addr_i + 1, mod 256.
  - IDLE, rd_ev (or rd pending): addr_o = ptr, we_o = 0, req_o = 1 next cycle; go RD_REQ.
  - WR_REQ: hold req_o, addr_o, wdata_o, we_o until gnt_i. On gnt_i, req_o = 0 next cycle; go IDLE.
  - RD_REQ: hold until gnt_i, then go RD_WAIT.
  - RD_WAIT: on rvalid_i, slv_data_o <= rdata_i, ptr <= ptr + 1 (mod 256); go IDLE.
- Latency: event to req_o = 1 cycle. rd_ev to slv_data_o update = 2 + bus latency.
- Timeout: per-state counter, cleared on entry to WR_REQ, RD_REQ and RD_WAIT.
  - If it reaches TIMEOUT: req_o = 0, err_o = 1, go IDLE.
  - Read timeout also sets slv_data_o = 8'hFF; ptr is not incremented.
- Pending events: an event arriving while not IDLE sets its 1-deep pending flag.
  - If that flag is already set, ovf_o = 1 and the new event is dropped.
  - Pending events are serviced from IDLE, write first.
- Simultaneous wr_ev and rd_ev in IDLE: write serviced, read made pending.
- rvalid_i outside RD_WAIT and gnt_i outside REQ states are ignored.
- enable_i low:
  - Next cycle: state IDLE, req_o = 0, pending flags cleared.
  - ptr, err_o and ovf_o are kept.
  - Events are ignored while low.
- clr_i: clears err_o and ovf_o. A set in the same cycle wins.

Test Plan:
- Write: slv_addr_i = 8'h10, slv_data_i = 8'hA5, raise slv_valid_i; gnt_i after 3 cycles -> one req_o with we_o = 1, addr_o = 8'h10, wdata_o = 8'hA5, held 3 cycles; ptr = 8'h11.
- Write then read: after the write above, raise slv_read_i; gnt immediate, rvalid_i 2 cycles later with rdata_i = 8'h3C -> addr_o = 8'h11, we_o = 0, slv_data_o = 8'h3C; second read -> addr_o = 8'h12.
- Wrap: slv_addr_i = 8'hFF, write -> ptr = 8'h00; next read -> addr_o = 0.
- Timeout: TIMEOUT = 4, read with gnt_i never asserted -> req_o drops after 4 cycles, err_o = 1, slv_data_o = 8'hFF; clr_i -> err_o = 0.
- Overrun and simultaneity: wr_ev and rd_ev same cycle -> write then read, in order; a third event during busy with a read already pending -> ovf_o = 1, only two bus transfers.
- Abort: deassert enable_i in RD_WAIT, then pulse rvalid_i -> busy_o = 0 next cycle, slv_data_o unchanged; synchronous rst_i mid-WR_REQ -> req_o = 0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/i2c_slave_regctrl.sv
// Turns I2C slave core byte events into register-bus writes and reads, tracking an
// auto-incrementing register pointer, with one-deep event buffering and bus timeouts.
module i2c_slave_regctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [7:0]        slv_addr_i,
    input  logic              slv_read_i,
    input  logic              slv_valid_i,
    input  logic [7:0]        slv_data_i,
    output logic [7:0]        slv_data_o,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        wdata_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [7:0]        rdata_i,
    output logic              busy_o,
    output logic              err_o,
    output logic              ovf_o,
    input  logic              clr_i
);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        valid_q;
    logic        read_q;
    logic [7:0]  addr_q;
    logic [7:0]  ptr;
    logic        wr_pend;
    logic        rd_pend;
    logic [15:0] cnt;

    logic wr_ev;
    logic rd_ev;
    logic tmo;

    assign wr_ev  = slv_valid_i & ~valid_q;
    assign rd_ev  = slv_read_i & ~read_q;
    assign tmo    = (cnt == TMO_LAST);
    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= 8'h00;
            ptr        <= 8'h00;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            cnt        <= 16'd0;
            slv_data_o <= 8'hFF;
            req_o      <= 1'b0;
            we_o       <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= 8'h00;
            err_o      <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            valid_q <= slv_valid_i;
            read_q  <= slv_read_i;
            addr_q  <= slv_addr_i;

            // Clear first so that any flag set later in this cycle takes precedence.
            if (clr_i) begin
                err_o <= 1'b0;
                ovf_o <= 1'b0;
            end

            if (!enable_i) begin
                state   <= IDLE;
                req_o   <= 1'b0;
                wr_pend <= 1'b0;
                rd_pend <= 1'b0;
            end else begin
                if (slv_addr_i != addr_q) begin
                    ptr <= slv_addr_i;
                end

                if (state != IDLE) begin
                    if (wr_ev) begin
                        if (wr_pend) ovf_o <= 1'b1;
                        else         wr_pend <= 1'b1;
                    end
                    if (rd_ev) begin
                        if (rd_pend) ovf_o <= 1'b1;
                        else         rd_pend <= 1'b1;
                    end
                end

                case (state)
                    IDLE: begin
                        cnt <= 16'd0;
                        if (wr_ev || wr_pend) begin
                            req_o   <= 1'b1;
                            we_o    <= 1'b1;
                            addr_o  <= ADDR_W'(slv_addr_i);
                            wdata_o <= slv_data_i;
                            ptr     <= slv_addr_i + 8'd1;
                            state   <= WR_REQ;
                            // One of two simultaneous write sources stays buffered.
                            wr_pend <= wr_ev & wr_pend;
                            if (rd_ev) begin
                                if (rd_pend) ovf_o <= 1'b1;
                                else         rd_pend <= 1'b1;
                            end
                        end else if (rd_ev || rd_pend) begin
                            req_o   <= 1'b1;
                            we_o    <= 1'b0;
                            addr_o  <= ADDR_W'(ptr);
                            state   <= RD_REQ;
                            rd_pend <= rd_ev & rd_pend;
                        end
                    end
                    WR_REQ: begin
                        if (gnt_i) begin
                            req_o <= 1'b0;
                            state <= IDLE;
                        end else if (tmo) begin
                            req_o <= 1'b0;
                            err_o <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    RD_REQ: begin
                        if (gnt_i) begin
                            req_o <= 1'b0;
                            cnt   <= 16'd0;
                            state <= RD_WAIT;
                        end else if (tmo) begin
                            req_o      <= 1'b0;
                            err_o      <= 1'b1;
                            slv_data_o <= 8'hFF;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    RD_WAIT: begin
                        if (rvalid_i) begin
                            slv_data_o <= rdata_i;
                            ptr        <= ptr + 8'd1;
                            state      <= IDLE;
                        end else if (tmo) begin
                            err_o      <= 1'b1;
                            slv_data_o <= 8'hFF;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regctrl.sv
// Directed bench for i2c_slave_regctrl: transaction-level reference model checked every
// cycle, plus literal expectations taken from the documented scenarios.
module tb_i2c_slave_regctrl;

    localparam int AW  = 10;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          enable_i = 1'b1;
    logic [7:0]    slv_addr_i = 8'h00;
    logic          slv_read_i = 1'b0;
    logic          slv_valid_i = 1'b0;
    logic [7:0]    slv_data_i = 8'h00;
    logic [7:0]    slv_data_o;
    logic          req_o;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [7:0]    wdata_o;
    logic          gnt_i = 1'b0;
    logic          rvalid_i;
    logic [7:0]    rdata_i;
    logic          busy_o;
    logic          err_o;
    logic          ovf_o;
    logic          clr_i = 1'b0;

    int tests = 0;
    int fails = 0;

    i2c_slave_regctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
        .slv_addr_i(slv_addr_i), .slv_read_i(slv_read_i), .slv_valid_i(slv_valid_i),
        .slv_data_i(slv_data_i), .slv_data_o(slv_data_o),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .busy_o(busy_o), .err_o(err_o), .ovf_o(ovf_o), .clr_i(clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Bus responder: grants after gnt_after cycles of request (0 = never),
    // returns read data rv_after cycles after a read grant (0 = never).
    int         gnt_after = 0;
    int         rv_after = 0;
    int         resp_age = 0;
    int         rv_cnt = 0;
    logic       rv_pulse = 1'b0;
    logic       rv_force = 1'b0;
    logic [7:0] rdata_val = 8'h00;

    assign rvalid_i = rv_pulse | rv_force;
    assign rdata_i  = rdata_val;

    always @(negedge clk) begin
        gnt_i    = 1'b0;
        rv_pulse = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) rv_pulse = 1'b1;
        end
        if (req_o) begin
            resp_age++;
            if (gnt_after != 0 && resp_age == gnt_after) begin
                gnt_i = 1'b1;
                if (!we_o) rv_cnt = rv_after;
            end
        end else begin
            resp_age = 0;
        end
    end

    // Reference model: one job in flight, pending events counted per kind.
    int   m_ptr = 0;
    int   m_addr = 0;
    int   m_wdata = 0;
    int   m_sdata = 255;
    bit   m_req = 0;
    bit   m_we = 0;
    bit   m_err = 0;
    bit   m_ovf = 0;
    int   job = 0;           // 0 none, 1 write, 2 read
    bit   granted = 0;
    int   age = 0;
    int   pend_w = 0;
    int   pend_r = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    int   pa = 0;

    task automatic model_step();
        bit wev;
        bit rev;
        int nw;
        int nr;
        int old_ptr;
        if (rst_i) begin
            m_ptr = 0; m_addr = 0; m_wdata = 0; m_sdata = 255;
            m_req = 0; m_we = 0; m_err = 0; m_ovf = 0;
            job = 0; granted = 0; age = 0; pend_w = 0; pend_r = 0;
            pv = 1'b0; pr = 1'b0; pa = 0;
        end else begin
            wev = slv_valid_i && !pv;
            rev = slv_read_i && !pr;
            pv = slv_valid_i;
            pr = slv_read_i;
            old_ptr = m_ptr;
            if (clr_i) begin
                m_err = 0;
                m_ovf = 0;
            end
            if (!enable_i) begin
                job = 0; m_req = 0; pend_w = 0; pend_r = 0;
                pa = int'(slv_addr_i);
            end else begin
                if (int'(slv_addr_i) != pa) m_ptr = int'(slv_addr_i);
                pa = int'(slv_addr_i);
                nw = pend_w + int'(wev);
                nr = pend_r + int'(rev);
                if (job == 0) begin
                    if (nw > 0) begin
                        nw--;
                        job = 1; age = 0; m_req = 1; m_we = 1;
                        m_addr = int'(slv_addr_i);
                        m_wdata = int'(slv_data_i);
                        m_ptr = (int'(slv_addr_i) + 1) % 256;
                    end else if (nr > 0) begin
                        nr--;
                        job = 2; granted = 0; age = 0; m_req = 1; m_we = 0;
                        m_addr = old_ptr;
                    end
                end else if (job == 1 && gnt_i) begin
                    job = 0; m_req = 0;
                end else if (job == 2 && !granted && gnt_i) begin
                    granted = 1; m_req = 0; age = 0;
                end else if (job == 2 && granted && rvalid_i) begin
                    m_sdata = int'(rdata_i);
                    m_ptr = (old_ptr + 1) % 256;
                    job = 0;
                end else begin
                    age++;
                    if (age >= TMO) begin
                        m_err = 1; m_req = 0;
                        if (job == 2) m_sdata = 255;
                        job = 0;
                    end
                end
                if (nw > 1) begin m_ovf = 1; nw = 1; end
                if (nr > 1) begin m_ovf = 1; nr = 1; end
                pend_w = nw;
                pend_r = nr;
            end
        end
    endtask

    logic xfer_we[$];
    int   xfer_addr[$];
    logic req_prev = 1'b0;

    always @(posedge clk) begin
        model_step();
        #1;
        check("cyc_req",   32'(req_o),      32'(m_req));
        check("cyc_we",    32'(we_o),       32'(m_we));
        check("cyc_addr",  32'(addr_o),     32'(m_addr));
        check("cyc_wdata", 32'(wdata_o),    32'(m_wdata));
        check("cyc_sdata", 32'(slv_data_o), 32'(m_sdata));
        check("cyc_busy",  32'(busy_o),     32'(job != 0));
        check("cyc_err",   32'(err_o),      32'(m_err));
        check("cyc_ovf",   32'(ovf_o),      32'(m_ovf));
        if (req_o && !req_prev) begin
            xfer_we.push_back(we_o);
            xfer_addr.push_back(int'(addr_o));
        end
        req_prev = req_o;
    end

    task automatic wait_req(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_seen"}, 32'(req_o), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic measure_req(output int n);
        n = 0;
        while (req_o && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;

        repeat (3) @(negedge clk);
        check("rst_sdata", 32'(slv_data_o), 32'hFF);
        check("rst_req",   32'(req_o),      32'd0);
        check("rst_busy",  32'(busy_o),     32'd0);
        check("rst_addr",  32'(addr_o),     32'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // Single write, grant on the third request cycle
        gnt_after = 3;
        slv_addr_i = 8'h10; slv_data_i = 8'hA5; slv_valid_i = 1'b1;
        wait_req("wr");
        check("wr_we",    32'(we_o),    32'd1);
        check("wr_addr",  32'(addr_o),  32'h010);
        check("wr_wdata", 32'(wdata_o), 32'hA5);
        measure_req(n);
        check("wr_req_cycles", 32'(n), 32'd3);
        slv_valid_i = 1'b0;

        // Reads follow the incremented pointer
        gnt_after = 1; rv_after = 2; rdata_val = 8'h3C;
        slv_read_i = 1'b1;
        wait_req("rd1");
        check("rd1_addr", 32'(addr_o), 32'h011);
        check("rd1_we",   32'(we_o),   32'd0);
        wait_idle("rd1");
        check("rd1_sdata", 32'(slv_data_o), 32'h3C);
        slv_read_i = 1'b0;
        @(negedge clk);
        rdata_val = 8'h5A;
        slv_read_i = 1'b1;
        wait_req("rd2");
        check("rd2_addr", 32'(addr_o), 32'h012);
        wait_idle("rd2");
        check("rd2_sdata", 32'(slv_data_o), 32'h5A);
        slv_read_i = 1'b0;

        // Pointer wraps after a write to 0xFF
        slv_addr_i = 8'hFF; slv_data_i = 8'h77; slv_valid_i = 1'b1;
        wait_req("wrap_wr");
        check("wrap_wr_addr", 32'(addr_o), 32'h0FF);
        wait_idle("wrap_wr");
        slv_valid_i = 1'b0;
        rdata_val = 8'h81;
        slv_read_i = 1'b1;
        wait_req("wrap_rd");
        check("wrap_rd_addr", 32'(addr_o), 32'h000);
        wait_idle("wrap_rd");
        check("wrap_rd_sdata", 32'(slv_data_o), 32'h81);
        slv_read_i = 1'b0;

        // Read never granted: timeout
        gnt_after = 0;
        @(negedge clk);
        slv_read_i = 1'b1;
        wait_req("tmo");
        measure_req(n);
        check("tmo_req_cycles", 32'(n), 32'd4);
        check("tmo_err",   32'(err_o),      32'd1);
        check("tmo_sdata", 32'(slv_data_o), 32'hFF);
        slv_read_i = 1'b0;
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        check("tmo_clr_err", 32'(err_o), 32'd0);

        // Simultaneous write+read, then a third event while the read is pending
        gnt_after = 2; rv_after = 1; rdata_val = 8'hC3;
        base = xfer_addr.size();
        @(negedge clk);
        slv_addr_i = 8'h20; slv_data_i = 8'h11; slv_valid_i = 1'b1; slv_read_i = 1'b1;
        @(negedge clk);
        check("ovr_first_we",   32'(we_o),   32'd1);
        check("ovr_first_addr", 32'(addr_o), 32'h020);
        slv_read_i = 1'b0;
        @(negedge clk);
        slv_read_i = 1'b1;
        repeat (12) @(negedge clk);
        check("ovr_flag",  32'(ovf_o), 32'd1);
        check("ovr_xfers", 32'(xfer_addr.size() - base), 32'd2);
        if (xfer_addr.size() >= base + 2) begin
            check("ovr_x0_we",   32'(xfer_we[base]),       32'd1);
            check("ovr_x0_addr", 32'(xfer_addr[base]),     32'h020);
            check("ovr_x1_we",   32'(xfer_we[base + 1]),   32'd0);
            check("ovr_x1_addr", 32'(xfer_addr[base + 1]), 32'h021);
        end
        check("ovr_sdata", 32'(slv_data_o), 32'hC3);
        slv_valid_i = 1'b0; slv_read_i = 1'b0;
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        check("ovr_clr", 32'(ovf_o), 32'd0);

        // Disable while waiting for read data; late rvalid is ignored
        gnt_after = 1; rv_after = 0;
        slv_read_i = 1'b1;
        wait_req("abort");
        @(negedge clk);
        check("abort_busy_before", 32'(busy_o), 32'd1);
        enable_i = 1'b0;
        @(negedge clk);
        check("abort_busy_after", 32'(busy_o), 32'd0);
        rdata_val = 8'hEE;
        rv_force = 1'b1;
        @(negedge clk);
        rv_force = 1'b0;
        check("abort_sdata", 32'(slv_data_o), 32'hC3);
        check("abort_req",   32'(req_o),      32'd0);
        slv_read_i = 1'b0;
        enable_i = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a write request
        gnt_after = 0;
        slv_addr_i = 8'h30; slv_data_i = 8'h99; slv_valid_i = 1'b1;
        wait_req("rstw");
        rst_i = 1'b1;
        @(negedge clk);
        check("rstw_req",   32'(req_o),      32'd0);
        check("rstw_busy",  32'(busy_o),     32'd0);
        check("rstw_sdata", 32'(slv_data_o), 32'hFF);
        check("rstw_we",    32'(we_o),       32'd0);
        check("rstw_addr",  32'(addr_o),     32'd0);
        check("rstw_wdata", 32'(wdata_o),    32'd0);
        check("rstw_err",   32'(err_o),      32'd0);
        check("rstw_ovf",   32'(ovf_o),      32'd0);
        rst_i = 1'b0;
        slv_valid_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
